seq_divider: RTL and testbench

- Iterative unsigned restoring divider; the inverse operation of the multiply-accumulate datapath.
- Takes a 2N-bit dividend (the accumulator width) and an N-bit divisor, and produces a 2N-bit quotient and an N-bit remainder.
- Computes one quotient bit per clock, using a start/busy/done handshake.
- Used downstream of the accumulator for averaging and normalisation of accumulated sums.

---
 rtl/seq_divider.sv | 91 +++++++++
 tb/tb_seq_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: a 2N-bit dividend divided by an N-bit divisor,
// producing one quotient bit per clock and handshaking through start/busy/done.
module seq_divider #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [2*N-1:0] shreg;
  logic [N-1:0]   dvsr;
  logic [N:0]     pr;
  logic [CW-1:0]  cnt;

  logic [N:0]     pr_sh, pr_nxt;
  logic [2*N-1:0] shreg_nxt;
  logic           ge;

  // The partial remainder stays below the divisor, so the shifted value fits in N+1 bits.
  always_comb begin
    pr_sh     = {pr[N-1:0], shreg[2*N-1]};
    ge        = (pr_sh >= {1'b0, dvsr});
    pr_nxt    = ge ? (pr_sh - {1'b0, dvsr}) : pr_sh;
    shreg_nxt = {shreg[2*N-2:0], ge};
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      shreg       <= '0;
      dvsr        <= '0;
      pr          <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            shreg <= dividend;
            dvsr  <= divisor;
            pr    <= '0;
            cnt   <= CW'(2*N);
            if (divisor == '0) begin
              state       <= DONE;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
            end else begin
              state       <= RUN;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          shreg <= shreg_nxt;
          pr    <= pr_nxt;
          cnt   <= cnt - CW'(1);
          // Outputs only change on the final iteration so they hold the previous result during RUN.
          if (cnt == CW'(1)) begin
            state     <= DONE;
            quotient  <= shreg_nxt;
            remainder <= pr_nxt[N-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed N=8 vector table with multi-cycle corner sequences,
// plus randomized N=32 operations checked against plain-arithmetic division.
module tb_seq_divider;

  logic clk, clear;

  logic        start8;
  logic [15:0] dividend8;
  logic [7:0]  divisor8;
  logic        busy8, done8, dbz8;
  logic [15:0] quotient8;
  logic [7:0]  remainder8;

  logic        start32;
  logic [63:0] dividend32;
  logic [31:0] divisor32;
  logic        busy32, done32, dbz32;
  logic [63:0] quotient32;
  logic [31:0] remainder32;

  int checks = 0;
  int errors = 0;

  seq_divider #(.N(8)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .quotient(quotient8), .remainder(remainder8)
  );

  seq_divider #(.N(32)) dut32 (
    .clk(clk), .clear(clear), .start(start32), .dividend(dividend32), .divisor(divisor32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .quotient(quotient32), .remainder(remainder32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive start for one edge (E0); returns #1 after E0.
  task automatic launch8(input logic [15:0] dd, input logic [7:0] dv);
    @(negedge clk);
    dividend8 = dd; divisor8 = dv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts edges since start (n0 already elapsed) until done is seen.
  task automatic wait_done8(input int n0, output int n);
    n = n0;
    while (!done8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n, seen;
    logic [15:0] prev_q;
    logic [63:0] dd, eq;
    logic [31:0] dv, er;
    logic        ez;
    logic [127:0] recon;

    tbl[0] = '{16'd1000,   8'd7,   16'd142,   8'd6,    1'b0};
    tbl[1] = '{16'd65535,  8'd1,   16'd65535, 8'd0,    1'b0};
    tbl[2] = '{16'd5,      8'd255, 16'd0,     8'd5,    1'b0};
    tbl[3] = '{16'h1234,   8'd0,   16'hFFFF,  8'h34,   1'b1};
    tbl[4] = '{16'd0,      8'd5,   16'd0,     8'd0,    1'b0};
    tbl[5] = '{16'd65279,  8'd255, 16'd255,   8'd254,  1'b0};
    tbl[6] = '{16'd300,    8'd16,  16'd18,    8'd12,   1'b0};
    tbl[7] = '{16'd65535,  8'd255, 16'd257,   8'd0,    1'b0};

    clear = 1'b1;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    start32 = 1'b0; dividend32 = '0; divisor32 = '0;
    #1;
    chk("reset busy8", busy8, 0);
    chk("reset done8", done8, 0);
    chk("reset dbz8", dbz8, 0);
    chk("reset q8", quotient8, 0);
    chk("reset r8", remainder8, 0);
    chk("reset q32", quotient32, 0);
    chk("reset busy32", busy32, 0);
    @(negedge clk); @(negedge clk);
    clear = 1'b0;

    // Table-driven N=8 vectors.
    prev_q = 16'd0;
    foreach (tbl[i]) begin
      launch8(tbl[i].dd, tbl[i].dv);
      chk($sformatf("v%0d dbz at accept", i), dbz8, tbl[i].z);
      if (!tbl[i].z) begin
        chk($sformatf("v%0d busy", i), busy8, 1);
        chk($sformatf("v%0d q hold", i), quotient8, prev_q);
      end
      wait_done8(1, n);
      chk($sformatf("v%0d latency", i), n, tbl[i].z ? 1 : 17);
      chk($sformatf("v%0d q", i), quotient8, tbl[i].q);
      chk($sformatf("v%0d r", i), remainder8, tbl[i].r);
      chk($sformatf("v%0d busy at done", i), busy8, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d done one cycle", i), done8, 0);
      prev_q = tbl[i].q;
    end

    // Start during RUN is ignored.
    launch8(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend8 = 16'd50000; divisor8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(5, n);
    chk("run-start latency", n, 17);
    chk("run-start q", quotient8, 16'd142);
    chk("run-start r", remainder8, 8'd6);

    // Back-to-back start in the DONE cycle.
    dividend8 = 16'd40000; divisor8 = 8'd200; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b done fell", done8, 0);
    chk("b2b busy", busy8, 1);
    wait_done8(1, n);
    chk("b2b latency", n, 17);
    chk("b2b q", quotient8, 16'd200);
    chk("b2b r", remainder8, 8'd0);

    // Asynchronous clear mid-RUN.
    launch8(16'd12345, 8'd11);
    repeat (5) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clr busy", busy8, 0);
    chk("clr q", quotient8, 0);
    chk("clr r", remainder8, 0);
    chk("clr done", done8, 0);
    #2 clear = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    chk("clr no done", seen, 0);
    launch8(16'd200, 8'd9);
    wait_done8(1, n);
    chk("post-clr latency", n, 17);
    chk("post-clr q", quotient8, 16'd22);
    chk("post-clr r", remainder8, 8'd2);

    // Randomized N=32 against arithmetic reference.
    for (int k = 0; k < 1000; k++) begin
      dd = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: dv = 32'hFFFF_FFFF;
        1: dv = $urandom_range(1, 15);
        2: dv = (k % 7 == 0) ? 32'd0 : 32'd1;
        default: dv = $urandom;
      endcase
      if (k % 50 == 0) dd = '1;
      if (k % 77 == 0) dd = {32'd0, $urandom};
      if (dv == 0) begin
        eq = '1; er = dd[31:0]; ez = 1'b1;
      end else begin
        eq = dd / {32'd0, dv};
        er = 32'(dd % {32'd0, dv});
        ez = 1'b0;
      end
      @(negedge clk);
      dividend32 = dd; divisor32 = dv; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      n = 1;
      while (!done32 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("r32 #%0d latency", k), n, ez ? 1 : 65);
      chk($sformatf("r32 #%0d q", k), quotient32, eq);
      chk($sformatf("r32 #%0d r", k), remainder32, er);
      chk($sformatf("r32 #%0d dbz", k), dbz32, ez);
      if (!ez) begin
        recon = 128'(quotient32) * 128'(divisor32) + 128'(remainder32);
        chk($sformatf("r32 #%0d invariant", k), recon, 128'(dd));
        chk($sformatf("r32 #%0d r<dv", k), remainder32 < divisor32, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
